// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator side of a single-port 32-bit word memory for the core's
//   load/store path. Requests arrive from the execute stage over a
//   valid/ready handshake. The unit performs RV32I byte, halfword and word
//   loads with sign or zero extension. The memory has no byte enables, so
//   sub-word stores are done by read-modify-write.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   req_valid/ready   request handshake (ready only while IDLE)
//   req_we            1=store, 0=load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      loads only: zero-extend when set
//   req_addr          byte address
//   req_wdata         store data, sub-word data in the low bits
//   rsp_valid/ready   response handshake
//   rsp_rdata         extended load data, 0 for stores and errors
//   rsp_err           misaligned or illegal-size request
//   mem_ce, mem_wre   memory strobes, active only in RD / WR
//   mem_ad            word-aligned memory address
//   mem_din           memory write data
//   mem_dout          memory read data, valid the cycle after RD
module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [2:0] {IDLE, RD, LATCH, WR, DONE} state_t;

  // Latched request. Only the low half of the store data is kept:
  // word stores load mem_din straight from the request port.
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
  } req_t;

  state_t state, nxt;
  req_t   rq;

  logic        accept, err_in;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] ld_ext, st_merge;

  assign accept = req_valid && req_ready;
  assign err_in = (req_size == 2'b11) ||
                  (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Strobes decode straight from state, so an async reset kills them at once.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign mem_ce    = (state == RD) || (state == WR);
  assign mem_wre   = (state == WR);
  assign mem_ad    = {rq.addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (accept) begin
               if (err_in)                          nxt = DONE;
               else if (!req_we || req_size != 2'b10) nxt = RD;
               else                                 nxt = WR;
             end
      RD:    nxt = LATCH;
      LATCH: nxt = rq.we ? WR : DONE;
      WR:    nxt = DONE;
      DONE:  if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Lane extraction / merge on the word returned by the read.
  always_comb begin
    bsel = mem_dout[7:0];
    case (rq.addr[1:0])
      2'd0: bsel = mem_dout[7:0];
      2'd1: bsel = mem_dout[15:8];
      2'd2: bsel = mem_dout[23:16];
      2'd3: bsel = mem_dout[31:24];
      default: bsel = mem_dout[7:0];
    endcase
    hsel = rq.addr[1] ? mem_dout[31:16] : mem_dout[15:0];

    case (rq.size)
      2'b00:   ld_ext = rq.uns ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
      2'b01:   ld_ext = rq.uns ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
      default: ld_ext = mem_dout;
    endcase

    st_merge = mem_dout;
    if (rq.size == 2'b00) begin
      case (rq.addr[1:0])
        2'd0: st_merge[7:0]   = rq.wdata[7:0];
        2'd1: st_merge[15:8]  = rq.wdata[7:0];
        2'd2: st_merge[23:16] = rq.wdata[7:0];
        2'd3: st_merge[31:24] = rq.wdata[7:0];
        default: st_merge = mem_dout;
      endcase
    end else if (rq.addr[1]) begin
      st_merge[31:16] = rq.wdata;
    end else begin
      st_merge[15:0]  = rq.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rq        <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_din   <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (accept) begin
          rq <= '{we: req_we, size: req_size, uns: req_unsigned,
                  addr: req_addr, wdata: req_wdata[15:0]};
          rsp_rdata <= '0;
          rsp_err   <= err_in;
          if (req_we && req_size == 2'b10 && !err_in) mem_din <= req_wdata;
        end
        LATCH: begin
          if (rq.we) mem_din   <= st_merge;
          else       rsp_rdata <= ld_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, mem_ce, mem_wre;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata, mem_din;
  logic [31:0] mem_dout = 32'h0;
  logic [7:0]  mem_ad;

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_ce(mem_ce),
    .mem_wre(mem_wre), .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, write on edge.
  logic [31:0] mem [0:63];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [7:0]  last_wad = 8'h0;
  logic [31:0] last_wdin = 32'h0;
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_wre) begin
        mem[mem_ad[7:2]] <= mem_din;
        wr_cnt    <= wr_cnt + 1;
        last_wad  <= mem_ad;
        last_wdin <= mem_din;
      end else begin
        mem_dout <= mem[mem_ad[7:2]];
        rd_cnt   <= rd_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: drive, measure latency, check response,
  // optionally hold backpressure for `hold` cycles, then release.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [7:0] a, input logic [31:0] wd,
                        input int lat, input logic [31:0] erd, input logic eerr,
                        input int erp, input int ewp, input int hold);
    int n, rd0, wr0;
    @(negedge clk);
    chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    // Garbage on the request bus must be ignored outside IDLE.
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_addr = ~a; req_wdata = ~wd;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, ":latency"}, 32'(n), 32'(lat));
    chk({tag, ":rdata"}, rsp_rdata, erd);
    chk({tag, ":err"}, 32'(rsp_err), 32'(eerr));
    if (hold > 0) begin
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ":hold_rdata"}, rsp_rdata, erd);
        chk({tag, ":hold_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ":hold_ce"}, 32'(mem_ce), 32'd0);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ":idle_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ":idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ":rd_pulses"}, 32'(rd_cnt - rd0), 32'(erp));
    chk({tag, ":wr_pulses"}, 32'(wr_cnt - wr0), 32'(ewp));
  endtask

  initial begin
    int wr0;
    // Reset state
    #12;
    chk("rst:req_ready", 32'(req_ready), 32'd1);
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:rsp_rdata", rsp_rdata, 32'h0);
    chk("rst:rsp_err",   32'(rsp_err), 32'd0);
    chk("rst:mem_ce",    32'(mem_ce), 32'd0);
    chk("rst:mem_wre",   32'(mem_wre), 32'd0);
    chk("rst:mem_ad",    32'(mem_ad), 32'd0);
    chk("rst:mem_din",   mem_din, 32'h0);
    @(negedge clk); rst = 1'b1;

    // Preload through word stores (2-cycle latency, write only)
    do_req("sw40", 1, 2'b10, 0, 8'd40, 32'h00000006, 2, 32'h0, 0, 0, 1, 0);
    do_req("sw44", 1, 2'b10, 0, 8'd44, 32'h00000005, 2, 32'h0, 0, 0, 1, 0);
    do_req("sw48", 1, 2'b10, 0, 8'd48, 32'h80FF1234, 2, 32'h0, 0, 0, 1, 0);
    chk("sw48:mem", mem[12], 32'h80FF1234);

    // Word loads
    do_req("lw40", 0, 2'b10, 0, 8'd40, 32'h0, 3, 32'h00000006, 0, 1, 0, 0);
    do_req("lw44", 0, 2'b10, 0, 8'd44, 32'h0, 3, 32'h00000005, 0, 1, 0, 0);

    // Sub-word loads on 0x80FF1234
    do_req("lb49",  0, 2'b00, 0, 8'd49, 32'h0, 3, 32'h00000012, 0, 1, 0, 0);
    do_req("lb50",  0, 2'b00, 0, 8'd50, 32'h0, 3, 32'hFFFFFFFF, 0, 1, 0, 0);
    do_req("lbu50", 0, 2'b00, 1, 8'd50, 32'h0, 3, 32'h000000FF, 0, 1, 0, 0);
    do_req("lh50",  0, 2'b01, 0, 8'd50, 32'h0, 3, 32'hFFFF80FF, 0, 1, 0, 0);
    do_req("lhu48", 0, 2'b01, 1, 8'd48, 32'h0, 3, 32'h00001234, 0, 1, 0, 0);
    do_req("lb51",  0, 2'b00, 0, 8'd51, 32'h0, 3, 32'hFFFFFF80, 0, 1, 0, 0);

    // Sub-word stores by read-modify-write
    do_req("sb49", 1, 2'b00, 0, 8'd49, 32'h000000AB, 4, 32'h0, 0, 1, 1, 0);
    chk("sb49:wad", 32'(last_wad), 32'd48);
    chk("sb49:wdin", last_wdin, 32'h80FFAB34);
    chk("sb49:mem", mem[12], 32'h80FFAB34);
    do_req("lw48a", 0, 2'b10, 0, 8'd48, 32'h0, 3, 32'h80FFAB34, 0, 1, 0, 0);

    do_req("sw48b", 1, 2'b10, 0, 8'd48, 32'h80FF1234, 2, 32'h0, 0, 0, 1, 0);
    do_req("sh50", 1, 2'b01, 0, 8'd50, 32'h0000BEEF, 4, 32'h0, 0, 1, 1, 0);
    chk("sh50:wdin", last_wdin, 32'hBEEF1234);
    chk("sh50:mem", mem[12], 32'hBEEF1234);
    // Upper store-data bits are ignored for sub-word stores
    do_req("sb51", 1, 2'b00, 0, 8'd51, 32'hFFFFFF5A, 4, 32'h0, 0, 1, 1, 0);
    chk("sb51:mem", mem[12], 32'h5AEF1234);

    // Errors: no memory access, 1-cycle latency
    do_req("lw42",  0, 2'b10, 0, 8'd42, 32'h0, 1, 32'h0, 1, 0, 0, 0);
    do_req("sh51",  1, 2'b01, 0, 8'd51, 32'h1111, 1, 32'h0, 1, 0, 0, 0);
    do_req("sz11",  0, 2'b11, 0, 8'd40, 32'h0, 1, 32'h0, 1, 0, 0, 0);
    do_req("sw41",  1, 2'b10, 0, 8'd41, 32'h12345678, 1, 32'h0, 1, 0, 0, 0);
    chk("sw41:mem", mem[10], 32'h00000006);

    // Backpressure: response held 5 cycles
    do_req("bp_lw40", 0, 2'b10, 0, 8'd40, 32'h0, 3, 32'h00000006, 0, 1, 0, 5);

    // Reset during LATCH of a byte store
    do_req("sw48c", 1, 2'b10, 0, 8'd48, 32'h80FF1234, 2, 32'h0, 0, 0, 1, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 8'd49;
    req_wdata = 32'h000000AB;
    wr0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);                 // RD
    req_valid = 1'b0;
    chk("rmid:rd_ce", 32'(mem_ce), 32'd1);
    @(negedge clk);                 // LATCH
    rst = 1'b0;
    #1;
    chk("rmid:req_ready", 32'(req_ready), 32'd1);
    chk("rmid:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rmid:mem_ce",    32'(mem_ce), 32'd0);
    chk("rmid:mem_wre",   32'(mem_wre), 32'd0);
    chk("rmid:mem_ad",    32'(mem_ad), 32'd0);
    chk("rmid:mem_din",   mem_din, 32'h0);
    chk("rmid:rsp_rdata", rsp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid:wr_pulses", 32'(wr_cnt - wr0), 32'd0);
    chk("rmid:mem", mem[12], 32'h80FF1234);
    do_req("post_lw48", 0, 2'b10, 0, 8'd48, 32'h0, 3, 32'h80FF1234, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
